// File: rtl/hough_seq_ctrl.sv
// Frame-level sequencer for the Hough datapath: clears the accumulator,
// streams one raster frame of pixels for voting, then scans the accumulator out.
module hough_seq_ctrl #(
  parameter int WIDTH     = 64,
  parameter int HEIGHT    = 64,
  parameter int HBLANK    = 4,
  parameter int ACC_DEPTH = 256
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic       abort_i,
  input  logic       hold_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       frame_o,
  output logic       line_o,
  output logic       pixel_req_o,
  output logic [7:0] col_o,
  output logic [7:0] row_o,
  output logic       acc_clr_o,
  output logic       acc_rd_o,
  output logic [7:0] acc_addr_o,
  output logic [7:0] frame_count_o
);

  // state  | meaning
  // IDLE   | waiting for start, counters at zero
  // CLEAR  | writing zero to every accumulator bin
  // VOTE   | one pixel per non-held cycle along the current line
  // HBLANK | idle gap between lines
  // SCAN   | reading every accumulator bin out
  // DONE   | one-cycle end-of-pass marker
  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_VOTE, S_HBLANK, S_SCAN, S_DONE
  } state_t;

  localparam logic [7:0] COL_LAST   = 8'(WIDTH - 1);
  localparam logic [7:0] ROW_LAST   = 8'(HEIGHT - 1);
  localparam logic [7:0] ADDR_LAST  = 8'(ACC_DEPTH - 1);
  localparam logic [7:0] BLANK_LOAD = (HBLANK > 0) ? 8'(HBLANK - 1) : 8'd0;

  state_t     state_q, state_d;
  logic [7:0] col_q, col_d;
  logic [7:0] row_q, row_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] blank_q, blank_d;
  logic [7:0] fcnt_q, fcnt_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      addr_q  <= '0;
      blank_q <= '0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      addr_q  <= addr_d;
      blank_q <= blank_d;
      fcnt_q  <= fcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    addr_d  = addr_q;
    blank_d = blank_q;
    fcnt_d  = fcnt_q;
    if (abort_i) begin
      state_d = S_IDLE;
      col_d   = '0;
      row_d   = '0;
      addr_d  = '0;
      blank_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          col_d   = '0;
          row_d   = '0;
          addr_d  = '0;
          blank_d = '0;
          if (start_i) state_d = S_CLEAR;
        end
        S_CLEAR: begin
          if (addr_q == ADDR_LAST) begin
            state_d = S_VOTE;
            addr_d  = '0;
            col_d   = '0;
            row_d   = '0;
          end else begin
            addr_d = addr_q + 8'd1;
          end
        end
        S_VOTE: begin
          if (!hold_i) begin
            if (col_q == COL_LAST) begin
              col_d = '0;
              if (row_q == ROW_LAST) begin
                state_d = S_SCAN;
                row_d   = '0;
              end else if (HBLANK == 0) begin
                row_d = row_q + 8'd1;
              end else begin
                state_d = S_HBLANK;
                blank_d = BLANK_LOAD;
              end
            end else begin
              col_d = col_q + 8'd1;
            end
          end
        end
        S_HBLANK: begin
          if (!hold_i) begin
            if (blank_q == 8'd0) begin
              state_d = S_VOTE;
              row_d   = row_q + 8'd1;
            end else begin
              blank_d = blank_q - 8'd1;
            end
          end
        end
        S_SCAN: begin
          if (!hold_i) begin
            if (addr_q == ADDR_LAST) begin
              state_d = S_DONE;
              addr_d  = '0;
              fcnt_d  = fcnt_q + 8'd1;
            end else begin
              addr_d = addr_q + 8'd1;
            end
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Hold only gates the transfer strobes; position outputs stay frozen.
  assign busy_o        = (state_q != S_IDLE);
  assign done_o        = (state_q == S_DONE);
  assign pixel_req_o   = (state_q == S_VOTE) && !hold_i;
  assign line_o        = pixel_req_o && (col_q == 8'd0);
  assign frame_o       = line_o && (row_q == 8'd0);
  assign acc_clr_o     = (state_q == S_CLEAR);
  assign acc_rd_o      = (state_q == S_SCAN) && !hold_i;
  assign col_o         = col_q;
  assign row_o         = row_q;
  assign acc_addr_o    = addr_q;
  assign frame_count_o = fcnt_q;

endmodule

// File: tb/tb_hough_seq_ctrl.sv
// Directed bench for hough_seq_ctrl: main instance 4x3 frame, HBLANK=2, 8 bins;
// second instance 1x4 frame, HBLANK=0, 2 bins.
module tb_hough_seq_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, abort = 1'b0, hold = 1'b0;
  logic start2 = 1'b0, abort2 = 1'b0, hold2 = 1'b0;

  logic       busy, done, frame, line, pix, clr, rd;
  logic [7:0] col, row, addr, fc;
  logic       busy2, done2, frame2, line2, pix2, clr2, rd2;
  logic [7:0] col2, row2, addr2, fc2;

  int checks = 0;
  int errors = 0;
  int exp_fc = 0;

  always #5 clk = ~clk;

  hough_seq_ctrl #(.WIDTH(4), .HEIGHT(3), .HBLANK(2), .ACC_DEPTH(8)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort), .hold_i(hold),
    .busy_o(busy), .done_o(done), .frame_o(frame), .line_o(line), .pixel_req_o(pix),
    .col_o(col), .row_o(row), .acc_clr_o(clr), .acc_rd_o(rd), .acc_addr_o(addr),
    .frame_count_o(fc)
  );

  hough_seq_ctrl #(.WIDTH(1), .HEIGHT(4), .HBLANK(0), .ACC_DEPTH(2)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start2), .abort_i(abort2), .hold_i(hold2),
    .busy_o(busy2), .done_o(done2), .frame_o(frame2), .line_o(line2), .pixel_req_o(pix2),
    .col_o(col2), .row_o(row2), .acc_clr_o(clr2), .acc_rd_o(rd2), .acc_addr_o(addr2),
    .frame_count_o(fc2)
  );

  // {busy, done, frame, line, pix, clr, rd, row, col, addr}
  wire [30:0] obs = {busy, done, frame, line, pix, clr, rd, row, col, addr};

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Expected outputs at unheld-timeline position e (1 = first cycle after Start edge).
  task automatic model(input int e, input bit held, output logic [30:0] v, output logic [30:0] m);
    int t, seg, off;
    v = '0;
    m = '1;
    if (e >= 1 && e <= 33) v[30] = 1'b1;
    if (e >= 1 && e <= 8) begin
      v[25] = 1'b1;
      v[7:0] = 8'(e - 1);
      m[23:8] = '0;
    end else if (e >= 9 && e <= 24) begin
      t = e - 9;
      seg = t / 6;
      off = t % 6;
      if (off < 4) begin
        v[26] = !held;
        v[27] = v[26] && (off == 0);
        v[28] = v[27] && (seg == 0);
        v[23:16] = 8'(seg);
        v[15:8] = 8'(off);
      end else begin
        m[23:8] = '0;
      end
    end else if (e >= 25 && e <= 32) begin
      v[24] = !held;
      v[7:0] = 8'(e - 25);
      m[23:8] = '0;
    end else if (e == 33) begin
      v[29] = 1'b1;
      m[23:0] = '0;
    end
  endtask

  // One pass on the main instance with optional hold windows and stray Start pulses.
  task automatic run_pass(input int ha_s, input int ha_n, input int hb_s, input int hb_n,
                          input int sa, input int sb);
    int holds;
    bit h;
    logic [30:0] v, m;
    holds = 0;
    @(negedge clk);
    start = 1'b1;
    #1;
    check("idle_before_start", {31'd0, busy}, 64'd0);
    for (int n = 1; n <= 34 + ha_n + hb_n; n++) begin
      @(negedge clk);
      start = (n == sa) || (n == sb);
      h = (n >= ha_s && n < ha_s + ha_n) || (n >= hb_s && n < hb_s + hb_n);
      hold = h;
      #1;
      model(n - holds, h, v, m);
      check($sformatf("pass_n%0d", n), obs & m, v & m);
      if (h) holds++;
    end
    exp_fc = (exp_fc + 1) % 256;
    check("frame_count_after_pass", fc, exp_fc);
    start = 1'b0;
    hold = 1'b0;
  endtask

  initial begin
    int dn, last;
    bit prev_done;
    #12;
    check("reset_outputs", {obs, fc}, 64'd0);
    rst_n = 1'b1;

    // Plain pass: Done in cycle 33, FrameCount 1.
    run_pass(0, 0, 0, 0, 0, 0);

    // WIDTH=1, HEIGHT=4, HBLANK=0: continuous pixels, Frame only on the first.
    @(negedge clk);
    start2 = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      start2 = 1'b0;
      #1;
      if (n >= 3 && n <= 6)
        check($sformatf("narrow_vote_n%0d", n), {pix2, line2, frame2, row2, col2},
              {1'b1, 1'b1, (n == 3), 8'(n - 3), 8'd0});
      if (n >= 7)
        check($sformatf("narrow_tail_n%0d", n), {busy2, done2, pix2},
              {(n <= 9), (n == 9), 1'b0});
    end

    // Hold 3 cycles at Row=1 Col=2 and 2 cycles at scan address 5: Done in cycle 38.
    run_pass(17, 3, 33, 2, 0, 0);

    // Abort at Row=1 Col=0.
    @(negedge clk);
    start = 1'b1;
    for (int n = 1; n <= 15; n++) begin
      @(negedge clk);
      start = 1'b0;
    end
    #1;
    check("abort_position", {line, row, col}, {1'b1, 8'd1, 8'd0});
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    #1;
    check("abort_idle", {obs, fc}, {31'd0, 8'(exp_fc)});
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      #1;
      check("abort_stays_idle", {busy, done, fc}, {1'b0, 1'b0, 8'(exp_fc)});
    end
    run_pass(0, 0, 0, 0, 0, 0);

    // Start re-pulsed in CLEAR and in SCAN is ignored.
    run_pass(0, 0, 0, 0, 3, 27);

    // Start held high: back-to-back passes, FrameCount wraps.
    @(negedge clk);
    start = 1'b1;
    dn = 0;
    last = 0;
    prev_done = 1'b0;
    for (int cyc = 1; cyc <= 256 * 34 + 40; cyc++) begin
      @(negedge clk);
      #1;
      if (prev_done) begin
        check("b2b_idle_gap", {busy, fc}, {1'b0, 8'(exp_fc)});
        if (dn == 256) begin
          start = 1'b0;
          break;
        end
      end
      prev_done = done;
      if (done) begin
        dn++;
        check("b2b_done_spacing", cyc - last, (dn == 1) ? 33 : 34);
        last = cyc;
        exp_fc = (exp_fc + 1) % 256;
      end
    end
    start = 1'b0;
    check("b2b_pass_count", dn, 256);
    check("b2b_fc_wrapped", fc, 8'd4);

    // Asynchronous reset in HBLANK.
    @(negedge clk);
    start = 1'b1;
    for (int n = 1; n <= 13; n++) begin
      @(negedge clk);
      start = 1'b0;
    end
    #1;
    check("pre_reset_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {obs, fc}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_fc = 0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      #1;
      check("post_reset_idle", {obs, fc}, 64'd0);
    end
    run_pass(0, 0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
